z_buffer_mem: RTL and testbench
===============================

Name: z_buffer_mem

Overview:
Depth-storage responder that serves the z-buffer request interface: buf_r_w, buf_addr, buf_data_w/buf_data_r, with data_r_valid/data_r_ready and data_w_valid/data_w_ready.
- Holds one Z_SIZE word per pixel in a register/BRAM array mapped at BASE_ADDR.
- Answers reads after a fixed latency and accepts single-cycle writes.
- Contains a hardware clear sweep, run after reset and on request, that fills the array with far depth (all ones).

Parameters:
Z_SIZE, 8, depth word width
X_RES, 4, horizontal resolution
Y_RES, 4, vertical resolution
DEPTH, X_RES*Y_RES, number of entries
IDX_W, $clog2(DEPTH), entry index width
ADDR_SIZE, 32, request address width
BASE_ADDR, 0, first mapped address
READ_LATENCY, 1, cycles from read acceptance to data_r_valid (legal 1..4)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous assert, active-low
buf_r_w  in  1  1 = read request, 0 = write
buf_addr  in  ADDR_SIZE  request address
buf_data_w  in  Z_SIZE  write data
buf_data_r  out  Z_SIZE  read data, registered
data_r_ready  in  1  read request (level); completes a read when high with data_r_valid
data_r_valid  out  1  read data valid
data_w_valid  in  1  write request
data_w_ready  out  1  write accept, combinational
clear_i  in  1  single-cycle pulse requesting a full clear sweep
clear_busy_o  out  1  clear sweep in progress
err_o  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (rst_ni low, asynchronous): data_r_valid=0, buf_data_r=0, clear_busy_o=1, err_o=0, sweep index=0, read-arm=1, clear_pending=0, state=SWEEP. Array contents are not reset; they are rewritten by the sweep.
- Address decode: in_range = BASE_ADDR <= buf_addr < BASE_ADDR+DEPTH; idx = (buf_addr-BASE_ADDR)[IDX_W-1:0].
- States:
  - SWEEP: writes all-ones to entry idx each cycle, idx 0..DEPTH-1, so the sweep takes exactly DEPTH cycles. On the last write go to IDLE; clear_busy_o falls the cycle after.
  - IDLE:
    - data_w_ready=1 in IDLE only; 0 in every other state and when clear_pending=1.
    - Write commits on every cycle with data_w_valid && data_w_ready && !buf_r_w. Back-to-back writes are allowed, one per cycle.
    - Read is accepted when data_r_ready && buf_r_w && read-arm && !data_w_valid. The block captures idx/in_range, clears read-arm and goes to RD_WAIT.
    - clear_i (or clear_pending) moves the block to SWEEP, with priority over a same-cycle read or write; that write is not accepted.
  - RD_WAIT: counts READ_LATENCY-1 cycles. On exit, buf_data_r is the array word, or all-ones if out of range, and data_r_valid=1; go to RD_RESP. With READ_LATENCY=1, data_r_valid is high the cycle after acceptance.
  - RD_RESP: holds data_r_valid and buf_data_r stable until a cycle with data_r_ready high. In that cycle the handshake completes: data_r_valid drops next cycle and the block returns to IDLE.
- Read-arm re-sets on any cycle with data_r_ready low. Each new read therefore needs data_r_ready to deassert and then reassert, so a held request is never serviced twice.
- Read-after-write: a write committed in cycle t is visible to a read accepted in t+1.
- clear_i while in RD_WAIT/RD_RESP sets clear_pending. The read completes with pre-clear data, then the block enters SWEEP. clear_busy_o=1 while clear_pending or in SWEEP.
- clear_i during SWEEP: ignored, the sweep is not restarted.
- Out-of-range write: handshaken normally, array unchanged. Out-of-range read returns all-ones.
- Reset mid-operation: the asynchronous reset aborts any read, write or sweep; the sweep restarts from entry 0 after deassertion.

Optional Feature:
Macro ZMEM_RANGE_ERR_EN.
- Defined: err_o sets (sticky) on any accepted out-of-range read or write; it is cleared only by reset or by entering SWEEP via clear_i.
- Not defined: err_o is tied to 0 and the range-check flop is absent; out-of-range behaviour is otherwise identical.

Test Plan:
Configuration for all scenarios: X_RES=Y_RES=4, BASE_ADDR=0x100, READ_LATENCY=2.
1. Release reset -> clear_busy_o high for exactly 16 cycles, data_w_ready low throughout; then read 0x105 -> buf_data_r=0xFF.
2. Write 0x3C to 0x10A -> data_w_ready high that cycle; read 0x10A accepted at t -> data_r_valid at t+2, data 0x3C, held 3 extra cycles while data_r_ready is low, drops the cycle after handshake.
3. Read 0x10A outstanding, clear_i pulsed at t+1 -> read returns 0x3C, then 16-cycle sweep; read 0x10A -> 0xFF.
4. Write 0x00 to 0x0FF -> handshake completes, all 16 entries unchanged; read 0x0FF -> 0xFF; err_o=1 with the macro, 0 without.
5. rst_ni low during sweep at entry 7 -> outputs take reset values immediately; after release the sweep runs 16 cycles from entry 0.
6. data_w_valid held high 16 cycles, addresses 0x100..0x10F with data 0x00..0x0F -> 16 writes accepted; readback of each address returns its index.

Source files
------------

// File: rtl/z_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module   : z_buffer_mem
// Purpose  : Depth-storage responder for the z-buffer request interface.
//            It holds one Z_SIZE depth word per pixel, mapped at BASE_ADDR.
//            Reads are answered after READ_LATENCY cycles and held until the
//            requester handshakes. Writes are accepted in a single cycle.
//            A hardware sweep fills the array with far depth (all ones).
//            The sweep runs after reset and again on each clear_i request.
// Ports    : clk_i, rst_ni      - clock (rising edge), async active-low reset
//            buf_r_w, buf_addr  - request direction (1 = read) and address
//            buf_data_w         - write data
//            buf_data_r         - registered read data
//            data_r_ready/valid - read request level / read data valid
//            data_w_valid/ready - write request / combinational write accept
//            clear_i            - one-cycle pulse requesting a clear sweep
//            clear_busy_o       - clear sweep pending or in progress
//            err_o              - sticky out-of-range flag
// Options  : `define ZMEM_RANGE_ERR_EN to enable the sticky err_o flag.
//            When it is undefined, err_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module z_buffer_mem #(
  parameter int unsigned                 Z_SIZE       = 8,
  parameter int unsigned                 X_RES        = 4,
  parameter int unsigned                 Y_RES        = 4,
  parameter int unsigned                 DEPTH        = X_RES * Y_RES,
  parameter int unsigned                 IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned                 ADDR_SIZE    = 32,
  parameter logic [ADDR_SIZE-1:0]        BASE_ADDR    = '0,
  parameter int unsigned                 READ_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 buf_r_w,
  input  logic [ADDR_SIZE-1:0] buf_addr,
  input  logic [Z_SIZE-1:0]    buf_data_w,
  output logic [Z_SIZE-1:0]    buf_data_r,
  input  logic                 data_r_ready,
  output logic                 data_r_valid,
  input  logic                 data_w_valid,
  output logic                 data_w_ready,
  input  logic                 clear_i,
  output logic                 clear_busy_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    ST_SWEEP   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_RESP = 2'd3
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  // RD_WAIT lasts READ_LATENCY-1 cycles. The counter runs 0..LAT_LAST.
  localparam int               LAT_LAST_I = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic [1:0]       LAT_LAST   = LAT_LAST_I[1:0];

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       sweep_idx_q, sweep_idx_d;
  logic                   arm_q, arm_d;
  logic                   clear_pend_q, clear_pend_d;
  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
  logic                   rd_inr_q, rd_inr_d;
  logic [1:0]             lat_cnt_q, lat_cnt_d;
  logic [Z_SIZE-1:0]      rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;

  logic [Z_SIZE-1:0]      mem_q [DEPTH];
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_waddr;
  logic [Z_SIZE-1:0]      mem_wdata;

  logic [ADDR_SIZE-1:0]   addr_off;
  logic                   in_range;
  logic [IDX_W-1:0]       req_idx;
  logic                   rd_accept;
  logic                   wr_commit;

  // Compare the offset instead of BASE_ADDR+DEPTH, so the upper bound
  // cannot overflow at the top of the address space.
  assign addr_off = buf_addr - BASE_ADDR;
  assign in_range = (buf_addr >= BASE_ADDR) && (addr_off < ADDR_SIZE'(DEPTH));
  assign req_idx  = addr_off[IDX_W-1:0];

  // A clear request in IDLE wins over a same-cycle write, so the write is
  // not accepted.
  assign data_w_ready = (state_q == ST_IDLE) && !clear_pend_q && !clear_i;
  assign clear_busy_o = (state_q == ST_SWEEP) || clear_pend_q;
  assign buf_data_r   = rdata_q;
  assign data_r_valid = rvalid_q;

  always_comb begin
    state_d      = state_q;
    sweep_idx_d  = sweep_idx_q;
    clear_pend_d = clear_pend_q;
    rd_idx_d     = rd_idx_q;
    rd_inr_d     = rd_inr_q;
    lat_cnt_d    = lat_cnt_q;
    rdata_d      = rdata_q;
    rvalid_d     = rvalid_q;
    mem_we       = 1'b0;
    mem_waddr    = sweep_idx_q;
    mem_wdata    = '1;
    rd_accept    = 1'b0;
    wr_commit    = 1'b0;

    case (state_q)
      ST_SWEEP: begin
        // clear_i is ignored here. A running sweep is never restarted.
        mem_we = 1'b1;
        if (sweep_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (clear_i || clear_pend_q) begin
          state_d      = ST_SWEEP;
          sweep_idx_d  = '0;
          clear_pend_d = 1'b0;
        end else begin
          wr_commit = data_w_valid && !buf_r_w;
          if (wr_commit && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = req_idx;
            mem_wdata = buf_data_w;
          end
          rd_accept = data_r_ready && buf_r_w && arm_q && !data_w_valid;
          if (rd_accept) begin
            rd_idx_d  = req_idx;
            rd_inr_d  = in_range;
            lat_cnt_d = '0;
            if (READ_LATENCY == 1) begin
              rdata_d  = in_range ? mem_q[req_idx] : '1;
              rvalid_d = 1'b1;
              state_d  = ST_RD_RESP;
            end else begin
              state_d  = ST_RD_WAIT;
            end
          end
        end
      end

      ST_RD_WAIT: begin
        if (clear_i) clear_pend_d = 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          rdata_d  = rd_inr_q ? mem_q[rd_idx_q] : '1;
          rvalid_d = 1'b1;
          state_d  = ST_RD_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      ST_RD_RESP: begin
        if (clear_i) clear_pend_d = 1'b1;
        if (data_r_ready) begin
          rvalid_d = 1'b0;
          // A clear that arrived during the read starts as soon as the
          // read data has been delivered.
          if (clear_pend_q || clear_i) begin
            state_d      = ST_SWEEP;
            sweep_idx_d  = '0;
            clear_pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_SWEEP;
    endcase
  end

  // Any cycle with data_r_ready low re-arms the read. A held request is
  // serviced only once.
  assign arm_d = !data_r_ready ? 1'b1 : (rd_accept ? 1'b0 : arm_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_SWEEP;
      sweep_idx_q  <= '0;
      arm_q        <= 1'b1;
      clear_pend_q <= 1'b0;
      rd_idx_q     <= '0;
      rd_inr_q     <= 1'b0;
      lat_cnt_q    <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      arm_q        <= arm_d;
      clear_pend_q <= clear_pend_d;
      rd_idx_q     <= rd_idx_d;
      rd_inr_q     <= rd_inr_d;
      lat_cnt_q    <= lat_cnt_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  // The storage array has no reset. The sweep rewrites every entry.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef ZMEM_RANGE_ERR_EN
  logic err_q, err_d;
  // Any entry into SWEEP outside of reset comes from a clear request.
  assign err_d = (state_q != ST_SWEEP && state_d == ST_SWEEP) ? 1'b0 :
                 (err_q | ((rd_accept || wr_commit) && !in_range));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_z_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_z_buffer_mem
// Purpose  : Scoreboard testbench for z_buffer_mem.
//            Configuration: 4x4 array, BASE_ADDR=0x100, READ_LATENCY=2.
//            Expected read data is queued when a read is issued. A monitor
//            pops the queue and compares on each read handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z_buffer_mem;
  localparam int unsigned ZS   = 8;
  localparam int unsigned AS   = 32;
  localparam logic [31:0] BASE = 32'h100;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          buf_r_w = 1'b0;
  logic [AS-1:0] buf_addr = '0;
  logic [ZS-1:0] buf_data_w = '0;
  logic [ZS-1:0] buf_data_r;
  logic          data_r_ready = 1'b0;
  logic          data_r_valid;
  logic          data_w_valid = 1'b0;
  logic          data_w_ready;
  logic          clear_i = 1'b0;
  logic          clear_busy_o;
  logic          err_o;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [ZS-1:0] exp_q [$];
  logic          exp_err;

  z_buffer_mem #(
    .Z_SIZE(ZS), .X_RES(4), .Y_RES(4), .ADDR_SIZE(AS),
    .BASE_ADDR(BASE), .READ_LATENCY(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .buf_r_w(buf_r_w), .buf_addr(buf_addr),
    .buf_data_w(buf_data_w), .buf_data_r(buf_data_r),
    .data_r_ready(data_r_ready), .data_r_valid(data_r_valid),
    .data_w_valid(data_w_valid), .data_w_ready(data_w_ready),
    .clear_i(clear_i), .clear_busy_o(clear_busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor. Each completed read handshake is checked against
  // the oldest queued expectation.
  always @(negedge clk_i) begin
    logic [ZS-1:0] e;
    if (rst_ni && data_r_valid && data_r_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdata_unexpected: got 0x%0h, expected no response", buf_data_r);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", {24'h0, buf_data_r}, {24'h0, e});
      end
    end
  end

  // The caller must be positioned at a negedge. The task counts busy cycles,
  // up to a bound of 100 cycles.
  task automatic wait_sweep(input string name);
    int cnt = 0;
    while (clear_busy_o && cnt < 100) begin
      cnt++;
      chk("wready_in_sweep", {31'h0, data_w_ready}, 32'h0);
      @(negedge clk_i);
    end
    chk(name, cnt, 32'd16);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk_i); #1;
    buf_r_w = 1'b0; buf_addr = a; buf_data_w = d; data_w_valid = 1'b1;
    @(negedge clk_i);
    chk("w_ready", {31'h0, data_w_ready}, 32'h1);
    @(posedge clk_i); #1;
    data_w_valid = 1'b0;
  endtask

  // The read is accepted in cycle t and must be valid at t+2. Valid and
  // data are then held for 'hold' more cycles before the handshake.
  task automatic do_read(input logic [31:0] a, input logic [7:0] e,
                         input int hold, input bit clr);
    @(posedge clk_i); #1;
    buf_r_w = 1'b1; buf_addr = a; data_w_valid = 1'b0; data_r_ready = 1'b1;
    exp_q.push_back(e);
    @(negedge clk_i);
    chk("lat_t0", {31'h0, data_r_valid}, 32'h0);
    @(posedge clk_i); #1;
    data_r_ready = 1'b0;
    if (clr) clear_i = 1'b1;
    @(negedge clk_i);
    chk("lat_t1", {31'h0, data_r_valid}, 32'h0);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("lat_t2", {31'h0, data_r_valid}, 32'h1);
    if (clr) chk("busy_pending", {31'h0, clear_busy_o}, 32'h1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk("hold_valid", {31'h0, data_r_valid}, 32'h1);
      chk("hold_data", {24'h0, buf_data_r}, {24'h0, e});
    end
    @(posedge clk_i); #1;
    data_r_ready = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    data_r_ready = 1'b0;
    @(negedge clk_i);
    chk("valid_drop", {31'h0, data_r_valid}, 32'h0);
  endtask

  initial begin
`ifdef ZMEM_RANGE_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Check the reset state, then release reset and time the power-up sweep.
    #1;
    chk("rst_valid", {31'h0, data_r_valid}, 32'h0);
    chk("rst_data", {24'h0, buf_data_r}, 32'h0);
    chk("rst_busy", {31'h0, clear_busy_o}, 32'h1);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_wready", {31'h0, data_w_ready}, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    wait_sweep("sweep_len_init");
    do_read(32'h105, 8'hFF, 0, 1'b0);

    // Write, then read back with the response held for three cycles.
    do_write(32'h10A, 8'h3C);
    do_read(32'h10A, 8'h3C, 3, 1'b0);

    // A clear during an outstanding read must not corrupt that read.
    do_read(32'h10A, 8'h3C, 0, 1'b1);
    wait_sweep("sweep_len_clear");
    do_read(32'h10A, 8'hFF, 0, 1'b0);
    chk("err_after_clear", {31'h0, err_o}, 32'h0);

    // Out-of-range write, then out-of-range read.
    do_write(32'h0FF, 8'h00);
    chk("err_oor", {31'h0, err_o}, {31'h0, exp_err});
    do_read(32'h0FF, 8'hFF, 0, 1'b0);
    do_read(32'h100, 8'hFF, 0, 1'b0);
    do_read(32'h10F, 8'hFF, 0, 1'b0);

    // Back-to-back write burst over the whole array, then readback.
    @(posedge clk_i); #1;
    buf_r_w = 1'b0; data_w_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      buf_addr = BASE + 32'(i);
      buf_data_w = 8'(i);
      @(negedge clk_i);
      chk("burst_wready", {31'h0, data_w_ready}, 32'h1);
      @(posedge clk_i); #1;
    end
    data_w_valid = 1'b0;
    for (int i = 0; i < 16; i++) do_read(BASE + 32'(i), 8'(i), 0, 1'b0);

    // Assert reset while the sweep writes entry 7, then release it.
    chk("pre_rst_data", {24'h0, buf_data_r}, 32'h0F);
    @(posedge clk_i); #1;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, data_r_valid}, 32'h0);
    chk("mid_rst_data", {24'h0, buf_data_r}, 32'h0);
    chk("mid_rst_busy", {31'h0, clear_busy_o}, 32'h1);
    chk("mid_rst_err", {31'h0, err_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    wait_sweep("sweep_len_rst");
    do_read(32'h103, 8'hFF, 0, 1'b0);
    do_read(32'h10E, 8'hFF, 0, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
